// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-channel result FIFOs, round-robin grant, one registered
// register-file write per cycle. Channel 0 carries raw load data and is aligned on entry.
module wb_arbiter #(
  parameter int NUM_CH = 3,
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_valid,
  output logic [NUM_CH-1:0]        ch_ready,
  input  logic [NUM_CH*5-1:0]      ch_rd_s,
  input  logic [NUM_CH*DATA_W-1:0] ch_rd_v,
  input  logic [2:0]               ld_funct3,
  input  logic [1:0]               ld_addr_lo,
  output logic                     regf_we,
  output logic [4:0]               rd_sel,
  output logic [DATA_W-1:0]        rd_v
);
  // Handshake: a channel pushes on a cycle where ch_valid[i] and ch_ready[i] are both
  // high at the rising edge; ch_ready depends only on the FIFO count, never on a pop.
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int CW   = $clog2(NUM_CH);
  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);
  localparam logic [CW:0]     NCH  = (CW + 1)'(NUM_CH);

  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] nonempty;
  logic [4:0]        head_rd [NUM_CH];
  logic [DATA_W-1:0] head_v  [NUM_CH];

  logic [DATA_W-1:0] ld_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_aligned;

  always_comb begin
    ld_word = ch_rd_v[DATA_W-1:0];
    ld_byte = ld_word[{ld_addr_lo, 3'b000} +: 8];
    ld_half = ld_word[{ld_addr_lo[1], 4'b0000} +: 16];
    case (ld_funct3)
      3'b000:  ld_aligned = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_aligned = {{(DATA_W-8){1'b0}}, ld_byte};
      3'b001:  ld_aligned = {{(DATA_W-16){ld_half[15]}}, ld_half};
      3'b101:  ld_aligned = {{(DATA_W-16){1'b0}}, ld_half};
      default: ld_aligned = ld_word;
    endcase
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [4:0]        mem_rd [DEPTH];
    logic [DATA_W-1:0] mem_v  [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [CNTW-1:0]   count;
    logic [DATA_W-1:0] in_v;

    if (i == 0) begin : g_ld
      assign in_v = ld_aligned;
    end else begin : g_raw
      assign in_v = ch_rd_v[i*DATA_W +: DATA_W];
    end

    assign ch_ready[i] = (count != FULL);
    assign push[i]     = ch_valid[i] && ch_ready[i];
    assign nonempty[i] = (count != '0);
    assign head_rd[i]  = mem_rd[rptr];
    assign head_v[i]   = mem_v[rptr];

    always_ff @(posedge clk) begin
      if (!rst && push[i]) begin
        mem_rd[wptr] <= ch_rd_s[i*5 +: 5];
        mem_v[wptr]  <= in_v;
      end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
      if (rst) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push[i]) wptr <= wptr + 1'b1;
        if (pop[i])  rptr <= rptr + 1'b1;
        if (push[i] && !pop[i])      count <= count + 1'b1;
        else if (!push[i] && pop[i]) count <= count - 1'b1;
      end
    end
  end

  logic [CW-1:0] ptr;
  logic [CW-1:0] grant_idx;
  logic          grant_any;
  logic [CW:0]   cand;

  // Scan channels starting at ptr; first non-empty one wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    pop       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = {1'b0, ptr} + (CW + 1)'(k);
      if (cand >= NCH) cand = cand - NCH;
      if (!grant_any && nonempty[cand[CW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[CW-1:0];
      end
    end
    if (grant_any) pop[grant_idx] = 1'b1;
  end

  // Writes to x0 still retire the entry but never assert the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      regf_we <= 1'b0;
      rd_sel  <= '0;
      rd_v    <= '0;
    end else if (grant_any) begin
      ptr     <= (grant_idx == CW'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      regf_we <= (head_rd[grant_idx] != 5'd0);
      rd_sel  <= head_rd[grant_idx];
      rd_v    <= head_v[grant_idx];
    end else begin
      regf_we <= 1'b0;
    end
  end
endmodule
